// File: rtl/simd_lockstep_alu_v2_if.sv
// Issue/writeback bundle for the lockstep SIMD ALU: request fields in,
// busy/done handshake and per-lane results out.
interface simd_lockstep_alu_v2_if #(
   parameter int LANES = 4,
   parameter int WIDTH = 32
);
   logic                   start;
   logic [2:0]             op;
   logic                   is_signed;
   logic [LANES-1:0]       lane_mask;
   logic [LANES*WIDTH-1:0] a;
   logic [LANES*WIDTH-1:0] b;
   logic                   busy;
   logic                   done;
   logic [LANES*WIDTH-1:0] result;
   logic [LANES-1:0]       div_by_zero;

   modport master (
      output start, op, is_signed, lane_mask, a, b,
      input  busy, done, result, div_by_zero
   );

   modport slave (
      input  start, op, is_signed, lane_mask, a, b,
      output busy, done, result, div_by_zero
   );
endinterface

// File: rtl/simd_lockstep_alu_v2.sv
// Lockstep SIMD ALU: one shared FSM and opcode, per-lane datapaths with a
// radix-2 restoring divider that all lanes step through together.
module simd_lockstep_alu_v2 #(
   parameter int LANES = 4,
   parameter int WIDTH = 32
) (
   input logic                   clk,
   input logic                   rst,
   simd_lockstep_alu_v2_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, EXEC, DIV_ITER, DONE} state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [2:0]       op_reg;
   logic             sgn_reg;
   logic [LANES-1:0] mask_reg;
   logic             busy_reg;
   logic             done_reg;

   logic accept;
   logic iterate;
   logic commit;
   logic start_is_div;

   assign accept       = (state_reg == IDLE) && bus.start;
   assign start_is_div = (bus.op == 3'd3) || (bus.op == 3'd4);
   // Count value WIDTH is the extra sign-fixup/commit step after the last quotient bit.
   assign iterate      = (state_reg == DIV_ITER) && (cnt_reg != CW'(WIDTH));
   assign commit       = (state_reg == EXEC) || ((state_reg == DIV_ITER) && (cnt_reg == CW'(WIDTH)));

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         op_reg    <= '0;
         sgn_reg   <= 1'b0;
         mask_reg  <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  op_reg    <= bus.op;
                  sgn_reg   <= bus.is_signed;
                  mask_reg  <= bus.lane_mask;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= start_is_div ? DIV_ITER : EXEC;
               end
            end
            EXEC: begin
               done_reg  <= 1'b1;
               state_reg <= DONE;
            end
            DIV_ITER: begin
               if (cnt_reg == CW'(WIDTH)) begin
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] a_in, b_in;
      logic [WIDTH-1:0] a_reg, b_reg, quo_reg, rem_reg, dvs_reg, res_reg;
      logic [WIDTH-1:0] lane_res;
      logic             dz_reg, lane_dz, neg_a, neg_b, a_lt_b;
      logic [WIDTH:0]   trial;

      assign a_in   = bus.a[gi*WIDTH +: WIDTH];
      assign b_in   = bus.b[gi*WIDTH +: WIDTH];
      assign neg_a  = sgn_reg & a_reg[WIDTH-1];
      assign neg_b  = sgn_reg & b_reg[WIDTH-1];
      assign a_lt_b = sgn_reg ? ($signed(a_reg) < $signed(b_reg)) : (a_reg < b_reg);
      // Borrow out of the trial subtraction means the shifted remainder is below the divisor.
      assign trial  = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};

      always_comb begin
         lane_res = '0;
         lane_dz  = 1'b0;
         case (op_reg)
            3'd0: lane_res = a_reg + b_reg;
            3'd1: lane_res = a_reg - b_reg;
            3'd2: lane_res = a_reg * b_reg;
            3'd3: begin
               lane_dz  = (b_reg == '0);
               lane_res = lane_dz ? '1 : ((neg_a ^ neg_b) ? -quo_reg : quo_reg);
            end
            3'd4: begin
               lane_dz  = (b_reg == '0);
               lane_res = neg_a ? -rem_reg : rem_reg;
            end
            3'd5: lane_res = a_lt_b ? a_reg : b_reg;
            3'd6: lane_res = a_lt_b ? b_reg : a_reg;
            default: lane_res = '0;
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            quo_reg <= '0;
            rem_reg <= '0;
            dvs_reg <= '0;
            res_reg <= '0;
            dz_reg  <= 1'b0;
         end else begin
            if (accept) begin
               a_reg   <= a_in;
               b_reg   <= b_in;
               rem_reg <= '0;
               quo_reg <= (bus.is_signed && a_in[WIDTH-1]) ? -a_in : a_in;
               dvs_reg <= (bus.is_signed && b_in[WIDTH-1]) ? -b_in : b_in;
            end else if (iterate) begin
               if (!trial[WIDTH]) begin
                  rem_reg <= trial[WIDTH-1:0];
                  quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
               end else begin
                  rem_reg <= {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
                  quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
               end
            end
            if (commit && mask_reg[gi]) begin
               res_reg <= lane_res;
               dz_reg  <= lane_dz;
            end
         end
      end

      assign bus.result[gi*WIDTH +: WIDTH] = res_reg;
      assign bus.div_by_zero[gi]           = dz_reg;
   end
endmodule
